// File: rtl/led_animator.sv
// led_animator: goal/win LED bar animations on BALL_CLOCK; outputs registered, an event at edge N shows frame 0 from edge N.
// Events while busy are dropped; define ANIM_PREEMPT_EN to let a higher-priority event restart the animation.
module led_animator #(
  parameter int LED_WIDTH  = 8,
  parameter int STEP_TICKS = 3,
  parameter int HOLD_TICKS = 6,
  parameter int REPEATS    = 2
) (
  input  logic                 BALL_CLOCK,
  input  logic                 RESET,
  input  logic                 goal_player_1,
  input  logic                 goal_player_2,
  input  logic                 win_player_1,
  input  logic                 win_player_2,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           anim_id
);

  localparam int MAX_TICKS = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int RW        = $clog2(REPEATS + 1);
  localparam int FW        = $clog2(LED_WIDTH);
  localparam int HALF      = LED_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

  state_t                 state, state_nxt;
  logic [FW-1:0]          frame, frame_nxt;
  logic [TW-1:0]          tick, tick_nxt;
  logic [RW-1:0]          rep, rep_nxt;
  logic [1:0]             id_nxt;
  logic                   done_nxt;
  logic                   busy_nxt;
  logic [LED_WIDTH-1:0]   led_nxt;
  logic                   ev;
  logic [1:0]             ev_id;
  logic                   start;
  logic                   is_win;
  logic                   last_frame;
  logic                   tick_end;
  int                     frame_len;

`ifdef ANIM_PREEMPT_EN
  function automatic logic [1:0] rank(input logic [1:0] id);
    case (id)
      2'd2:    rank = 2'd3;
      2'd3:    rank = 2'd2;
      2'd0:    rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction
`endif

  // Win fill grows from the centre pair toward the winner's side.
  function automatic logic [LED_WIDTH-1:0] frame_pattern(input logic [1:0] id, input int k);
    logic [LED_WIDTH-1:0] p;
    int j;
    p = '0;
    j = k - HALF + 1;
    for (int b = 0; b < LED_WIDTH; b++) begin
      case (id)
        2'd0:    p[b] = (b == LED_WIDTH - 1 - k);
        2'd1:    p[b] = (b == k);
        default: begin
          if (k < HALF)
            p[b] = (b == k) || (b == LED_WIDTH - 1 - k);
          else if (id == 2'd2)
            p[b] = (b >= HALF - 1) && (b <= HALF + j);
          else
            p[b] = (b >= HALF - 1 - j) && (b <= HALF);
        end
      endcase
    end
    return p;
  endfunction

  always_comb begin
    ev = win_player_1 | win_player_2 | goal_player_1 | goal_player_2;
    if (win_player_1)       ev_id = 2'd2;
    else if (win_player_2)  ev_id = 2'd3;
    else if (goal_player_1) ev_id = 2'd0;
    else                    ev_id = 2'd1;
  end

  always_ff @(posedge BALL_CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      frame   <= '0;
      tick    <= '0;
      rep     <= '0;
      anim_id <= 2'd0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame   <= frame_nxt;
      tick    <= tick_nxt;
      rep     <= rep_nxt;
      anim_id <= id_nxt;
      led     <= led_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    is_win     = anim_id[1];
    last_frame = int'(frame) == (is_win ? LED_WIDTH - 2 : LED_WIDTH - 1);
    frame_len  = (is_win && last_frame) ? HOLD_TICKS : STEP_TICKS;
    tick_end   = int'(tick) == frame_len - 1;

    state_nxt = state;
    frame_nxt = frame;
    tick_nxt  = tick;
    rep_nxt   = rep;
    id_nxt    = anim_id;
    done_nxt  = 1'b0;
    start     = 1'b0;

    case (state)
      IDLE: start = ev;
      RUN: begin
        if (tick_end) begin
          tick_nxt = '0;
          if (last_frame) state_nxt = BLANK;
          else            frame_nxt = frame + FW'(1);
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      BLANK: begin
        if (int'(tick) == STEP_TICKS - 1) begin
          tick_nxt = '0;
          rep_nxt  = rep - RW'(1);
          if (rep == RW'(1)) begin
            // Completion edge still accepts a new event; done pulses regardless.
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            start     = ev;
          end else begin
            state_nxt = RUN;
            frame_nxt = '0;
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef ANIM_PREEMPT_EN
    if (state != IDLE && !done_nxt && ev && (rank(ev_id) > rank(anim_id)))
      start = 1'b1;
`endif

    if (start) begin
      state_nxt = RUN;
      frame_nxt = '0;
      tick_nxt  = '0;
      rep_nxt   = RW'(REPEATS);
      id_nxt    = ev_id;
    end
  end

  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    led_nxt  = '0;
    if (state_nxt == RUN)
      led_nxt = frame_pattern(id_nxt, int'(frame_nxt));
  end

endmodule
